// File: rtl/can_bus_model_pkg.sv
// Shared definitions for the CAN bus model: fault mode encodings and default
// stuck-dominant timeout, used by the RTL and the bench alike.
package can_bus_model_pkg;

    typedef enum logic [1:0] {
        FM_NONE = 2'd0,
        FM_DOM  = 2'd1,
        FM_REC  = 2'd2,
        FM_FLIP = 2'd3
    } fault_mode_e;

    localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/can_bus_delay_line.sv
// Per-node transmit history with a clamped tap: delay 0 is the live input,
// delay d is the input as captured d clock edges ago.
module can_bus_delay_line #(
    parameter int MAXDELAY = 8,
    parameter int DW       = $clog2(MAXDELAY + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          din,
    input  logic [DW-1:0] delay,
    output logic          tap
);

    localparam logic [DW-1:0] DMAX = DW'(MAXDELAY);

    logic [MAXDELAY-1:0] sr;
    logic [MAXDELAY:0]   hist;
    logic [DW-1:0]       sel;

    // hist[0] is the live bit, hist[i] the bit from i cycles back
    assign hist = {sr, din};
    assign sel  = (delay > DMAX) ? DMAX : delay;
    assign tap  = hist[sel];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sr <= '1;
        else          sr <= hist[MAXDELAY-1:0];
    end

endmodule

// File: rtl/can_bus_model.sv
// Wired-AND CAN bus with per-sender propagation delay, single-node rx fault
// injection and a sticky stuck-dominant monitor.
module can_bus_model
    import can_bus_model_pkg::*;
#(
    parameter int N        = 2,
    parameter int MAXDELAY = 8,
    parameter int DW       = $clog2(MAXDELAY + 1),
    parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N-1:0]    tx_i,
    output logic [N-1:0]    rx_o,
    input  logic [N*DW-1:0] delay_i,
    input  logic            fault_trig_i,
    input  logic [3:0]      fault_node_i,
    input  logic [1:0]      fault_mode_i,
    output logic            bus_o,
    output logic            dom_timeout_o,
    output logic [15:0]     dom_cnt_o
);

    logic [N-1:0] tap;
    logic [N-1:0] raw;
    logic [3:0]   f_node;
    fault_mode_e  f_mode;

    for (genvar k = 0; k < N; k++) begin : g_node
        can_bus_delay_line #(.MAXDELAY(MAXDELAY), .DW(DW)) u_dl (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .din     (tx_i[k]),
            .delay   (delay_i[k*DW +: DW]),
            .tap     (tap[k])
        );
    end

    assign bus_o = &tx_i;

    // A node always hears itself undelayed; everyone else arrives via their tap
    always_comb begin
        raw = tx_i;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++)
                if (k != j) raw[j] = raw[j] & tap[k];
    end

    always_comb begin
        rx_o = raw;
        for (int j = 0; j < N; j++) begin
            if (f_node == 4'(j)) begin
                case (f_mode)
                    FM_DOM:  rx_o[j] = 1'b0;
                    FM_REC:  rx_o[j] = 1'b1;
                    FM_FLIP: rx_o[j] = ~raw[j];
                    default: ;
                endcase
            end
        end
    end

    // Out-of-range node indices collapse to no fault so rx_o is never touched
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_node <= '0;
            f_mode <= FM_NONE;
        end else if (fault_trig_i) begin
            f_node <= fault_node_i;
            f_mode <= (int'(fault_node_i) < N) ? fault_mode_e'(fault_mode_i) : FM_NONE;
        end else if (f_mode == FM_FLIP) begin
            f_mode <= FM_NONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dom_cnt_o     <= '0;
            dom_timeout_o <= 1'b0;
        end else begin
            if (bus_o)                      dom_cnt_o <= '0;
            else if (dom_cnt_o != 16'hFFFF) dom_cnt_o <= dom_cnt_o + 16'd1;
            if (!bus_o && dom_cnt_o == 16'(TIMEOUT - 1)) dom_timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_can_bus_model.sv
// Bench for can_bus_model (N=3, MAXDELAY=8): directed scenarios plus random
// traffic against a cycle-history reference model of the bus.
module tb_can_bus_model;
    import can_bus_model_pkg::*;

    localparam int N  = 3;
    localparam int MD = 8;
    localparam int DW = 4;
    localparam int TO = DEFAULT_TIMEOUT;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [N-1:0]    tx_i;
    logic [N-1:0]    rx_o;
    logic [N*DW-1:0] delay_i;
    logic            fault_trig_i;
    logic [3:0]      fault_node_i;
    logic [1:0]      fault_mode_i;
    logic            bus_o;
    logic            dom_timeout_o;
    logic [15:0]     dom_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: per-cycle tx history and spec-level fault/count state
    int           cyc      = 0;
    int           last_rst = -1;
    logic [N-1:0] hist [0:4095];
    int           m_node   = 0;
    int           m_mode   = 0;
    int           exp_cnt  = 0;
    logic         exp_to   = 1'b0;

    can_bus_model #(.N(N), .MAXDELAY(MD), .TIMEOUT(TO)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .tx_i          (tx_i),
        .rx_o          (rx_o),
        .delay_i       (delay_i),
        .fault_trig_i  (fault_trig_i),
        .fault_node_i  (fault_node_i),
        .fault_mode_i  (fault_mode_i),
        .bus_o         (bus_o),
        .dom_timeout_o (dom_timeout_o),
        .dom_cnt_o     (dom_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            hist[cyc % 4096] = '1;
            last_rst = cyc;
            m_mode   = 0;
            m_node   = 0;
            exp_cnt  = 0;
            exp_to   = 1'b0;
        end else begin
            hist[cyc % 4096] = tx_i;
            if (fault_trig_i) begin
                m_node = int'(fault_node_i);
                m_mode = (m_node >= N) ? 0 : int'(fault_mode_i);
            end else if (m_mode == 3) begin
                m_mode = 0;
            end
            if (&tx_i) exp_cnt = 0;
            else if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt == TO) exp_to = 1'b1;
        end
        cyc++;
    end

    function automatic logic m_tap(int k);
        int d;
        int idx;
        d = int'(delay_i[k*DW +: DW]);
        if (d > MD) d = MD;
        if (d == 0) return tx_i[k];
        if (!rst_n_i) return 1'b1;
        idx = cyc - d;
        if (idx <= last_rst) return 1'b1;
        return hist[idx % 4096][k];
    endfunction

    function automatic logic [N-1:0] m_rx();
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) begin
            r[j] = tx_i[j];
            for (int k = 0; k < N; k++)
                if (k != j) r[j] = r[j] & m_tap(k);
            if (rst_n_i && j == m_node) begin
                if (m_mode == 1)      r[j] = 1'b0;
                else if (m_mode == 2) r[j] = 1'b1;
                else if (m_mode == 3) r[j] = ~r[j];
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] tx, input logic trig,
                         input logic [3:0] node, input logic [1:0] mode);
        @(negedge clk_i);
        tx_i         = tx;
        fault_trig_i = trig;
        fault_node_i = node;
        fault_mode_i = mode;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('1, 1'b0, 4'd0, 2'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i      = 1'b0;
        tx_i         = '1;
        fault_trig_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        #1;
        n_checks++;
        if (rx_o !== 3'b111) $display("FAIL reset_rx: got %b want 111", rx_o); else n_pass++;
        n_checks++;
        if (bus_o !== 1'b1) $display("FAIL reset_bus: got %b want 1", bus_o); else n_pass++;
        n_checks++;
        if (dom_cnt_o !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", dom_cnt_o); else n_pass++;
        n_checks++;
        if (dom_timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b want 0", dom_timeout_o); else n_pass++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle(10);
    endtask

    task automatic test_single_delay();
        logic [N-1:0] exp;
        delay_i = {4'd0, 4'd3, 4'd3};
        idle(4);
        for (int i = 0; i < 8; i++) begin
            drive((i == 0) ? 3'b110 : 3'b111, 1'b0, 4'd0, 2'd0);
            exp = 3'b111;
            if (i == 0) exp[0] = 1'b0;
            if (i == 3) begin exp[1] = 1'b0; exp[2] = 1'b0; end
            n_checks++;
            if (rx_o !== exp) $display("FAIL single_delay c%0d: got %b want %b", i, rx_o, exp);
            else n_pass++;
            n_checks++;
            if (rx_o !== m_rx()) $display("FAIL single_delay_model c%0d: got %b want %b", i, rx_o, m_rx());
            else n_pass++;
        end
    endtask

    task automatic test_multi_delay();
        logic [N-1:0] exp;
        delay_i = {4'd5, 4'd2, 4'd0};
        idle(9);
        for (int i = 0; i < 8; i++) begin
            drive((i == 0) ? 3'b000 : 3'b111, 1'b0, 4'd0, 2'd0);
            exp = 3'b111;
            if (i == 0) exp = 3'b000;
            if (i == 2) begin exp[0] = 1'b0; exp[2] = 1'b0; end
            if (i == 5) begin exp[0] = 1'b0; exp[1] = 1'b0; end
            n_checks++;
            if (rx_o !== exp) $display("FAIL multi_delay c%0d: got %b want %b", i, rx_o, exp);
            else n_pass++;
        end
    endtask

    task automatic test_clamp();
        logic [N-1:0] seq15 [0:11];
        logic [N-1:0] seq8  [0:11];
        logic [N-1:0] exp;
        delay_i = {4'd0, 4'd0, 4'd15};
        idle(9);
        for (int i = 0; i < 12; i++) begin
            drive((i == 0) ? 3'b110 : 3'b111, 1'b0, 4'd0, 2'd0);
            seq15[i] = rx_o;
            exp = 3'b111;
            if (i == 0) exp[0] = 1'b0;
            if (i == 8) begin exp[1] = 1'b0; exp[2] = 1'b0; end
            n_checks++;
            if (rx_o !== exp) $display("FAIL clamp15 c%0d: got %b want %b", i, rx_o, exp);
            else n_pass++;
        end
        delay_i = {4'd0, 4'd0, 4'd8};
        idle(9);
        for (int i = 0; i < 12; i++) begin
            drive((i == 0) ? 3'b110 : 3'b111, 1'b0, 4'd0, 2'd0);
            seq8[i] = rx_o;
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (seq15[i] !== seq8[i]) $display("FAIL clamp_vs_8 c%0d: got %b want %b", i, seq15[i], seq8[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fault();
        // {tx, trig, node, mode, expected rx in the same cycle}
        logic [12:0] steps [0:19] = '{
            {3'b111, 1'b1, 4'd1, 2'd1, 3'b111},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b101},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b101},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b101},
            {3'b111, 1'b1, 4'd1, 2'd0, 3'b101},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b111},
            {3'b111, 1'b1, 4'd2, 2'd3, 3'b111},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b011},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b111},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b111},
            {3'b101, 1'b1, 4'd0, 2'd2, 3'b000},
            {3'b101, 1'b0, 4'd0, 2'd0, 3'b001},
            {3'b101, 1'b0, 4'd0, 2'd0, 3'b001},
            {3'b111, 1'b1, 4'd0, 2'd3, 3'b111},
            {3'b111, 1'b1, 4'd1, 2'd1, 3'b110},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b101},
            {3'b111, 1'b1, 4'd5, 2'd1, 3'b101},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b111},
            {3'b111, 1'b1, 4'd0, 2'd0, 3'b111},
            {3'b111, 1'b0, 4'd0, 2'd0, 3'b111}
        };
        delay_i = '0;
        idle(2);
        for (int i = 0; i < 20; i++) begin
            drive(steps[i][12:10], steps[i][9], steps[i][8:5], steps[i][4:3]);
            n_checks++;
            if (rx_o !== steps[i][2:0]) $display("FAIL fault s%0d: got %b want %b", i, rx_o, steps[i][2:0]);
            else n_pass++;
            n_checks++;
            if (rx_o !== m_rx()) $display("FAIL fault_model s%0d: got %b want %b", i, rx_o, m_rx());
            else n_pass++;
        end
        idle(1);
    endtask

    task automatic test_random();
        logic [N-1:0] t;
        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0) delay_i = N*DW'($urandom);
            for (int b = 0; b < N; b++) t[b] = ($urandom_range(0, 3) != 0);
            drive(t, ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
            n_checks++;
            if (rx_o !== m_rx()) $display("FAIL rand_rx c%0d: got %b want %b", i, rx_o, m_rx());
            else n_pass++;
            n_checks++;
            if (bus_o !== &t) $display("FAIL rand_bus c%0d: got %b want %b", i, bus_o, &t);
            else n_pass++;
            n_checks++;
            if (dom_cnt_o !== 16'(exp_cnt)) $display("FAIL rand_cnt c%0d: got %0d want %0d", i, dom_cnt_o, exp_cnt);
            else n_pass++;
            n_checks++;
            if (dom_timeout_o !== exp_to) $display("FAIL rand_timeout c%0d: got %b want %b", i, dom_timeout_o, exp_to);
            else n_pass++;
        end
        fault_trig_i = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        delay_i = '0;
        idle(2);
        for (int i = 0; i < 40; i++) begin
            drive(3'b110, 1'b0, 4'd0, 2'd0);
            n_checks++;
            if (dom_cnt_o !== 16'(i)) $display("FAIL timeout_cnt c%0d: got %0d want %0d", i, dom_cnt_o, i);
            else n_pass++;
            n_checks++;
            if (dom_timeout_o !== (i >= TO)) $display("FAIL timeout_flag c%0d: got %b want %b", i, dom_timeout_o, (i >= TO));
            else n_pass++;
        end
        drive(3'b111, 1'b0, 4'd0, 2'd0);
        n_checks++;
        if (dom_timeout_o !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", dom_timeout_o); else n_pass++;
        drive(3'b111, 1'b0, 4'd0, 2'd0);
        n_checks++;
        if (dom_cnt_o !== 16'd0) $display("FAIL timeout_cnt_clear: got %0d want 0", dom_cnt_o); else n_pass++;
        n_checks++;
        if (dom_timeout_o !== 1'b1) $display("FAIL timeout_sticky2: got %b want 1", dom_timeout_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        delay_i = {4'd5, 4'd5, 4'd5};
        idle(6);
        repeat (3) drive(3'b110, 1'b0, 4'd0, 2'd0);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        tx_i    = '1;
        #1;
        n_checks++;
        if (rx_o !== 3'b111) $display("FAIL rstmid_rx: got %b want 111", rx_o); else n_pass++;
        n_checks++;
        if (dom_cnt_o !== 16'd0) $display("FAIL rstmid_cnt: got %0d want 0", dom_cnt_o); else n_pass++;
        n_checks++;
        if (dom_timeout_o !== 1'b0) $display("FAIL rstmid_timeout: got %b want 0", dom_timeout_o); else n_pass++;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(3'b111, 1'b0, 4'd0, 2'd0);
            n_checks++;
            if (rx_o !== 3'b111) $display("FAIL rstmid_after c%0d: got %b want 111", i, rx_o);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n_i      = 1'b0;
        tx_i         = '1;
        delay_i      = '0;
        fault_trig_i = 1'b0;
        fault_node_i = '0;
        fault_mode_i = '0;
        test_reset();
        test_single_delay();
        test_multi_delay();
        test_clamp();
        test_fault();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
